core_switch_pio: RTL

//   Avalon-MM slave input port for board switches/buttons. Parametrised in width.
//   Per-bit 2-stage synchroniser, optional debounce filter, per-bit edge capture

---
 rtl/core_switch_pio_if.sv | 20 ++
 rtl/core_switch_pio.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/core_switch_pio_if.sv
// Avalon-MM slave bus bundle for core_switch_pio: register select, strobes,
// write data and registered read data.
interface core_switch_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, read, write, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, read, write, writedata,
        output readdata
    );
endinterface

// File: rtl/core_switch_pio.sv
// Switch/button input port for the Nios core.
// Contains a per-bit 2-flop synchroniser, an optional debounce filter, per-bit
// edge capture with selectable polarity (RW1C), and a masked level interrupt.
// Optional feature macro: SWITCH_PIO_DEBOUNCE_EN. When it is defined, a new
// level must hold DEBOUNCE_CYCLES clocks before it becomes the stable level.
// When it is not defined, the stable level is the synchroniser output.
// Register map: 0 DATA (RO), 1 MASK (RW), 2 EDGE (RW1C), 3 POL (RW, 1 = falling).
module core_switch_pio #(
    parameter int WIDTH           = 18,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                 clk,
    input  logic                 reset,
    core_switch_pio_if.slave     bus,
    input  logic [WIDTH-1:0]     in_port,
    output logic                 irq
);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE = 2'd2;
    localparam logic [1:0] ADDR_POL  = 2'd3;

    logic [WIDTH-1:0] sync_1;
    logic [WIDTH-1:0] sync_2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] mask_reg;
    logic [WIDTH-1:0] pol_reg;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] edge_clr;
    logic [31:0]      rd_mux;
    logic             wr_en;
    logic             unused_bus_bits;

    // Reads have no side effects and writedata bits above WIDTH are ignored.
    assign unused_bus_bits = ^{bus.read, bus.writedata};

    assign wr_en = bus.chipselect & bus.write;

    // Two-flop synchroniser for the asynchronous pins.
    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking assignments so every
        // flop samples the pre-edge value of its source.
        if (reset) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= in_port;
            sync_2 <= sync_1;
        end
    end

`ifdef SWITCH_PIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] db_cnt [WIDTH];

    // Debounce: a bit's stable level follows sync_2 only after the new level
    // has been seen on DEBOUNCE_CYCLES consecutive clocks.
    always_ff @(posedge clk) begin
        // NOTE: the counter array is per-bit state, not storage; it must be
        // reset so a transition pending at reset is discarded.
        if (reset) begin
            stable <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_2[i] != stable[i]) begin
                    if (db_cnt[i] == CNT_LAST) begin
                        stable[i] <= sync_2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end
`else
    assign stable = sync_2;
`endif

    // Edge qualifiers: rising edges when POL=0, falling edges when POL=1;
    // W1C clear mask from a write to the EDGE register.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        edge_clr = '0;
        edge_set = (stable & ~stable_d & ~pol_reg) | (~stable & stable_d & pol_reg);
        if (wr_en && (bus.address == ADDR_EDGE)) begin
            edge_clr = bus.writedata[WIDTH-1:0];
        end
    end

    // Software registers and edge capture; a set beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_d <= '0;
            mask_reg <= '0;
            pol_reg  <= '0;
            edge_cap <= '0;
        end else begin
            stable_d <= stable;
            edge_cap <= (edge_cap & ~edge_clr) | edge_set;
            if (wr_en && (bus.address == ADDR_MASK)) begin
                mask_reg <= bus.writedata[WIDTH-1:0];
            end
            if (wr_en && (bus.address == ADDR_POL)) begin
                pol_reg <= bus.writedata[WIDTH-1:0];
            end
        end
    end

    // Read mux, zero-extended to the 32-bit bus.
    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_DATA: rd_mux = 32'(stable);
            ADDR_MASK: rd_mux = 32'(mask_reg);
            ADDR_EDGE: rd_mux = 32'(edge_cap);
            ADDR_POL:  rd_mux = 32'(pol_reg);
            default:   rd_mux = '0;
        endcase
    end

    // Registered read data (fixed latency 1) and registered interrupt.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.readdata <= '0;
            irq          <= 1'b0;
        end else begin
            bus.readdata <= rd_mux;
            irq          <= |(edge_cap & mask_reg);
        end
    end

endmodule
